// File: rtl/tbu_sched_if.sv
// Bus between the traceback scheduler and the ACS array / survivor RAMs / tbu pair.
interface tbu_sched_if #(
  parameter int unsigned DEPTH = 32
);
  localparam int unsigned AW = $clog2(DEPTH);

  logic          dec_valid;
  logic [3:0]    mem_we;
  logic [AW-1:0] mem_waddr;
  logic [AW-1:0] rd_addr;
  logic [1:0]    rd_bank_0;
  logic [1:0]    rd_bank_1;
  logic          tbu_en_0;
  logic          tbu_sel_0;
  logic          tbu_en_1;
  logic          tbu_sel_1;

  // Scheduler side
  modport master (
    input  dec_valid,
    output mem_we, mem_waddr, rd_addr, rd_bank_0, rd_bank_1,
    output tbu_en_0, tbu_sel_0, tbu_en_1, tbu_sel_1
  );

  // Datapath side (ACS, survivor RAMs, tbu blocks)
  modport slave (
    output dec_valid,
    input  mem_we, mem_waddr, rd_addr, rd_bank_0, rd_bank_1,
    input  tbu_en_0, tbu_sel_0, tbu_en_1, tbu_sel_1
  );
endinterface

// File: rtl/tbu_sched.sv
// Survivor-memory write sequencing and two-TBU traceback scheduling for the
// K=4 Viterbi decoder. Four banks rotate: write p, train p-1, idle p-2, decode p-3.
module tbu_sched #(
  parameter int unsigned DEPTH = 32
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        stop,
  output logic        busy,
  output logic        err,
  tbu_sched_if.master bus
);
  localparam int unsigned AW = $clog2(DEPTH);
  localparam logic [AW-1:0] LAST = AW'(DEPTH - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    DRAIN1 = 2'd2,
    DRAIN2 = 2'd3
  } state_t;

  state_t        state;
  state_t        state_nxt;

  logic [AW-1:0] wcnt;
  logic [1:0]    p;
  logic [1:0]    warm;
  logic          primed;
  logic          stop_pend;

  logic          wr_act;
  logic          active;
  logic          wrap;
  logic          err_ev;
  logic          trn_on;
  logic          dec_on;
  logic [1:0]    trn_bank;
  logic [1:0]    dec_bank;

  logic          en0_nxt;
  logic          sel0_nxt;
  logic          en1_nxt;
  logic          sel1_nxt;

  // Per-cycle qualifiers derived from state and counters
  always_comb begin
    wr_act   = (state == RUN) && bus.dec_valid;
    active   = wr_act || (state == DRAIN1) || (state == DRAIN2);
    wrap     = active && (wcnt == LAST);
    err_ev   = (state == RUN) && !bus.dec_valid;
    // Training needs two written banks behind it; decoding needs a trained bank from the last period
    trn_on   = active && (((state == RUN) && (warm == 2'd2)) || (state == DRAIN1));
    dec_on   = active && ((((state == RUN) || (state == DRAIN1)) && primed) || (state == DRAIN2));
    trn_bank = p - 2'd1;
    dec_bank = p + 2'd1;  // p-3 mod 4: the bank older than the one trained last period
  end

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (start) state_nxt = RUN;
      end
      RUN: begin
        if (err_ev) begin
          state_nxt = IDLE;
        end else if (wrap && (stop || stop_pend)) begin
          // Without two written banks there is nothing to decode, so skip draining
          state_nxt = (warm == 2'd2) ? DRAIN1 : IDLE;
        end
      end
      DRAIN1: begin
        if (wrap) state_nxt = DRAIN2;
      end
      DRAIN2: begin
        if (wrap) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Output decode: RAM write/read controls and next TBU enables
  always_comb begin
    bus.mem_we    = '0;
    bus.mem_waddr = '0;
    bus.rd_addr   = '0;
    bus.rd_bank_0 = '0;
    bus.rd_bank_1 = '0;
    en0_nxt       = 1'b0;
    sel0_nxt      = 1'b0;
    en1_nxt       = 1'b0;
    sel1_nxt      = 1'b0;
    busy          = (state != IDLE);

    if (wr_act) begin
      bus.mem_we    = 4'b0001 << p;
      bus.mem_waddr = wcnt;
    end
    if (active) begin
      bus.rd_addr = LAST - wcnt;
    end

    // TBU(p%2) trains, the other one decodes
    if (p[0]) begin
      if (trn_on) begin
        bus.rd_bank_1 = trn_bank;
        en1_nxt       = 1'b1;
      end
      if (dec_on) begin
        bus.rd_bank_0 = dec_bank;
        en0_nxt       = 1'b1;
        sel0_nxt      = 1'b1;
      end
    end else begin
      if (trn_on) begin
        bus.rd_bank_0 = trn_bank;
        en0_nxt       = 1'b1;
      end
      if (dec_on) begin
        bus.rd_bank_1 = dec_bank;
        en1_nxt       = 1'b1;
        sel1_nxt      = 1'b1;
      end
    end
  end

  // TBU enables/selects follow the read address by one cycle to line up with RAM data
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      bus.tbu_en_0  <= 1'b0;
      bus.tbu_sel_0 <= 1'b0;
      bus.tbu_en_1  <= 1'b0;
      bus.tbu_sel_1 <= 1'b0;
    end else begin
      bus.tbu_en_0  <= en0_nxt;
      bus.tbu_sel_0 <= sel0_nxt;
      bus.tbu_en_1  <= en1_nxt;
      bus.tbu_sel_1 <= sel1_nxt;
    end
  end

  // Stream counters, latched stop and sticky error
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wcnt      <= '0;
      p         <= '0;
      warm      <= '0;
      primed    <= 1'b0;
      stop_pend <= 1'b0;
      err       <= 1'b0;
    end else if (state == IDLE) begin
      if (start) begin
        wcnt      <= '0;
        p         <= '0;
        warm      <= '0;
        primed    <= 1'b0;
        stop_pend <= 1'b0;
        err       <= 1'b0;
      end
    end else begin
      if (err_ev) err <= 1'b1;
      if ((state == RUN) && stop) stop_pend <= 1'b1;
      if (active) begin
        wcnt <= wcnt + AW'(1);
        if (wrap) begin
          p <= p + 2'd1;
          if (warm != 2'd2) warm <= warm + 2'd1;
          if (warm == 2'd2) primed <= 1'b1;
        end
      end
    end
  end
endmodule

// File: tb/tb_tbu_sched.sv
// Self-checking bench for tbu_sched: random streams checked against a
// period-indexed model of the bank rotation.
module tb_tbu_sched;
  localparam int unsigned DEPTH = 32;

  logic clk   = 1'b0;
  logic rst   = 1'b0;
  logic start = 1'b0;
  logic stop  = 1'b0;
  logic busy;
  logic err;

  tbu_sched_if #(.DEPTH(DEPTH)) bus ();

  tbu_sched #(.DEPTH(DEPTH)) dut (
    .clk  (clk),
    .rst  (rst),
    .start(start),
    .stop (stop),
    .busy (busy),
    .err  (err),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;
  bit exp_err = 1'b0;
  // Expected registered TBU controls for the next cycle
  bit pe0 = 1'b0, ps0 = 1'b0, pe1 = 1'b0, ps1 = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_tbu(input string pfx);
    chk({pfx, "_en0"},  bus.tbu_en_0,  pe0);
    chk({pfx, "_sel0"}, bus.tbu_sel_0, ps0);
    chk({pfx, "_en1"},  bus.tbu_en_1,  pe1);
    chk({pfx, "_sel1"}, bus.tbu_sel_1, ps1);
  endtask

  task automatic chk_quiet(input string pfx, input bit exp_busy);
    chk({pfx, "_we"},    bus.mem_we,    0);
    chk({pfx, "_waddr"}, bus.mem_waddr, 0);
    chk({pfx, "_raddr"}, bus.rd_addr,   0);
    chk({pfx, "_bank0"}, bus.rd_bank_0, 0);
    chk({pfx, "_bank1"}, bus.rd_bank_1, 0);
    chk({pfx, "_busy"},  busy,          exp_busy);
  endtask

  // One stream from start to IDLE. stop_at/gap_at/rst_at are stream-cycle
  // indices (-1 = never); the last written period is stop_at / DEPTH.
  task automatic stream(input int stop_at, input int gap_at, input int rst_at, input bit stop_w_start);
    int e_last, k, off, xb0, xb1;
    bit run, drain, trn, dec, odd;
    e_last = (stop_at >= 0) ? stop_at / DEPTH : (1 << 20);

    @(posedge clk); #1;
    start = 1'b1;
    stop  = stop_w_start;
    bus.dec_valid = 1'($urandom);
    @(negedge clk);
    chk("start_busy", busy, 0);
    chk("start_err",  err,  exp_err);
    exp_err = 1'b0;

    for (int c = 0; c < 2000; c++) begin
      k     = c / DEPTH;
      off   = c % DEPTH;
      run   = (k <= e_last);
      drain = !run && (e_last >= 2) && (k <= e_last + 2);
      if (!run && !drain) break;

      @(posedge clk); #1;
      start = ($urandom_range(0, 15) == 0);
      stop  = run ? (c == stop_at) : ($urandom_range(0, 7) == 0);
      bus.dec_valid = run ? (c != gap_at) : 1'($urandom);

      if (c == rst_at) begin
        #2 rst = 1'b0;
        #1;
        chk_quiet("rst", 0);
        chk("rst_err",  err, 0);
        pe0 = 0; ps0 = 0; pe1 = 0; ps1 = 0;
        chk_tbu("rst");
        @(posedge clk); #1;
        rst = 1'b1; start = 1'b0; stop = 1'b0; bus.dec_valid = 1'b0;
        @(negedge clk);
        chk_quiet("post_rst", 0);
        chk_tbu("post_rst");
        exp_err = 1'b0;
        return;
      end

      @(negedge clk);
      if (run && (c == gap_at)) begin
        chk_quiet("gap", 1);
        chk_tbu("gap");
        pe0 = 0; ps0 = 0; pe1 = 0; ps1 = 0;
        exp_err = 1'b1;
        break;
      end

      trn = (k >= 2) && (k <= e_last + 1);
      dec = (k >= 3) && (k <= e_last + 2);
      odd = (k % 2) == 1;
      xb0 = (trn && !odd) ? (k - 1) % 4 : (dec && odd)  ? (k - 3) % 4 : 0;
      xb1 = (trn && odd)  ? (k - 1) % 4 : (dec && !odd) ? (k - 3) % 4 : 0;

      chk("we",    bus.mem_we,    run ? (1 << (k % 4)) : 0);
      chk("waddr", bus.mem_waddr, run ? off : 0);
      chk("raddr", bus.rd_addr,   DEPTH - 1 - off);
      chk("bank0", bus.rd_bank_0, xb0);
      chk("bank1", bus.rd_bank_1, xb1);
      chk("busy",  busy,          1);
      chk("err",   err,           0);
      chk_tbu("lag");
      pe0 = (trn && !odd) || (dec && odd);
      ps0 = dec && odd;
      pe1 = (trn && odd) || (dec && !odd);
      ps1 = dec && !odd;
    end

    // First IDLE cycle: enables still show the last read cycle
    @(posedge clk); #1;
    start = 1'b0; stop = 1'b0; bus.dec_valid = 1'b0;
    @(negedge clk);
    chk_quiet("idle", 0);
    chk("idle_err", err, exp_err);
    chk_tbu("idle_lag");
    pe0 = 0; ps0 = 0; pe1 = 0; ps1 = 0;
    @(posedge clk); #1;
    @(negedge clk);
    chk_quiet("idle2", 0);
    chk_tbu("idle2");
  endtask

  initial begin
    bus.dec_valid = 1'b0;
    #12;
    chk_quiet("reset", 0);
    chk("reset_err", err, 0);
    chk_tbu("reset");
    @(posedge clk); #1 rst = 1'b1;

    // stop alone in IDLE does nothing
    @(posedge clk); #1 stop = 1'b1;
    @(negedge clk);
    chk("idle_stop_busy", busy, 0);
    @(posedge clk); #1 stop = 1'b0;
    @(negedge clk);
    chk("idle_stop_busy2", busy, 0);

    // Full stream, stop at cycle 10 of period 5; stop given with start is dropped
    stream(5 * DEPTH + 10, -1, -1, 1'b1);
    // dec_valid gap at stream cycle 40
    stream(-1, 40, -1, 1'b0);
    // Restart after error; stop in the last cycle of period 2
    stream(3 * DEPTH - 1, -1, -1, 1'b0);
    // Stops during warm-up: straight to IDLE, no TBU activity
    stream(int'($urandom_range(0, DEPTH - 1)), -1, -1, 1'b0);
    stream(DEPTH + int'($urandom_range(0, DEPTH - 1)), -1, -1, 1'b0);
    // Random gap while decoding
    stream(-1, int'($urandom_range(2 * DEPTH, 5 * DEPTH)), -1, 1'b0);
    // Reset in the middle of a decode period
    stream(-1, -1, 3 * DEPTH + 5, 1'b0);
    // Random stop point after warm-up
    stream(4 * DEPTH + int'($urandom_range(0, DEPTH - 1)), -1, -1, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
